// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: drives one IR+DR scan through a tracked IEEE 1149.1 TAP, with abort-to-Reset and TDO capture.
module jtag_scan_sequencer #(
    parameter int VECTORMAXWIDTH = 32,
    parameter int INSTRMAXWIDTH  = 5
) (
    input  logic                      jtagClk,
    input  logic                      jtagRst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [INSTRMAXWIDTH-1:0]  instruction,
    input  logic [2:0]                instrWidth,
    input  logic [VECTORMAXWIDTH-1:0] testVector,
    input  logic [5:0]                vectorWidth,
    input  logic                      jtagTdo,
    output logic                      jtagTms,
    output logic                      jtagTdi,
    output logic [3:0]                tapState,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [VECTORMAXWIDTH-1:0] tdoData
);
    localparam int CW = $clog2(VECTORMAXWIDTH);
    localparam int IW = $clog2(INSTRMAXWIDTH);

    typedef enum logic [3:0] {
        RESET, IDLE, DR_SCAN, IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR,
        EXIT2_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR
    } tap_t;

    tap_t                      state_q, state_d;
    logic                      busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic                      dr_phase_q, dr_phase_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [INSTRMAXWIDTH-1:0]  instr_q, instr_d;
    logic [VECTORMAXWIDTH-1:0] vec_q, vec_d, tdo_q, tdo_d;
    logic [2:0]                n_q, n_d;
    logic [5:0]                m_q, m_d;
    logic                      tms_scan, accept, hit_reset, fin;

    always_comb begin
        tms_scan = 1'b1;
        case (state_q)
            RESET:                                     tms_scan = 1'b0;
            DR_SCAN:                                   tms_scan = !dr_phase_q;
            IR_SCAN, CAPTURE_IR, CAPTURE_DR, UPDATE_DR: tms_scan = 1'b0;
            SHIFT_IR:                                  tms_scan = cnt_q == CW'(n_q - 3'd1);
            SHIFT_DR:                                  tms_scan = cnt_q == CW'(m_q - 6'd1);
            default:                                   tms_scan = 1'b1;
        endcase
        // Without a scan in flight, any state other than Reset/Idle heads back to Reset.
        jtagTms = jtagRst || abort || (busy_q ? tms_scan : !(state_q inside {RESET, IDLE}));
        jtagTdi = state_q == SHIFT_IR ? instr_q[cnt_q[IW-1:0]] :
                  state_q == SHIFT_DR ? vec_q[cnt_q] : 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:      state_d = jtagTms ? RESET     : IDLE;
            IDLE:       state_d = jtagTms ? DR_SCAN   : IDLE;
            DR_SCAN:    state_d = jtagTms ? IR_SCAN   : CAPTURE_DR;
            IR_SCAN:    state_d = jtagTms ? RESET     : CAPTURE_IR;
            CAPTURE_IR: state_d = jtagTms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_d = jtagTms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_d = jtagTms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_d = jtagTms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_d = jtagTms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_d = jtagTms ? DR_SCAN   : IDLE;
            CAPTURE_DR: state_d = jtagTms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_d = jtagTms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_d = jtagTms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_d = jtagTms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_d = jtagTms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_d = jtagTms ? DR_SCAN   : IDLE;
            default:    state_d = RESET;
        endcase
    end

    always_comb begin
        accept     = start && !abort && !busy_q && state_q == IDLE;
        hit_reset  = abort && state_q != RESET && state_d == RESET;
        fin        = busy_q && state_q == UPDATE_DR && state_d == IDLE;
        busy_d     = accept || (busy_q && !hit_reset && !fin);
        done_d     = fin;
        aborted_d  = hit_reset;
        cnt_d      = (state_q inside {SHIFT_IR, SHIFT_DR}) && !jtagTms ? cnt_q + 1'b1 : '0;
        dr_phase_d = accept ? 1'b0 : state_q == UPDATE_IR ? 1'b1 : dr_phase_q;
        instr_d    = accept ? instruction : instr_q;
        vec_d      = accept ? testVector : vec_q;
        n_d        = accept ? (instrWidth inside {3'd3, 3'd4, 3'd5} ? instrWidth : 3'd5) : n_q;
        m_d        = accept ? (vectorWidth inside {6'd8, 6'd16, 6'd24, 6'd32} ? vectorWidth : 6'd32) : m_q;
        tdo_d      = accept ? '0 : tdo_q;
        if (!accept && state_q == SHIFT_DR)
            tdo_d[cnt_q] = jtagTdo;
    end

    always_ff @(posedge jtagClk or posedge jtagRst) begin
        if (jtagRst) begin
            state_q    <= RESET;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            dr_phase_q <= 1'b0;
            cnt_q      <= '0;
            instr_q    <= '0;
            vec_q      <= '0;
            tdo_q      <= '0;
            n_q        <= 3'd0;
            m_q        <= 6'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            dr_phase_q <= dr_phase_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            vec_q      <= vec_d;
            tdo_q      <= tdo_d;
            n_q        <= n_d;
            m_q        <= m_d;
        end
    end

    assign tapState = state_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign tdoData  = tdo_q;
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: random and directed scans checked every cycle against a queue-based scan-plan model.
module tb_jtag_scan_sequencer;
    logic        jtagClk = 1'b0, jtagRst = 1'b1, start = 1'b0, abort = 1'b0, jtagTdo = 1'b0;
    logic [4:0]  instruction = '0;
    logic [2:0]  instrWidth = '0;
    logic [31:0] testVector = '0;
    logic [5:0]  vectorWidth = '0;
    logic        jtagTms, jtagTdi, busy, done, aborted;
    logic [3:0]  tapState;
    logic [31:0] tdoData;

    jtag_scan_sequencer dut (
        .jtagClk(jtagClk), .jtagRst(jtagRst), .start(start), .abort(abort),
        .instruction(instruction), .instrWidth(instrWidth), .testVector(testVector),
        .vectorWidth(vectorWidth), .jtagTdo(jtagTdo), .jtagTms(jtagTms), .jtagTdi(jtagTdi),
        .tapState(tapState), .busy(busy), .done(done), .aborted(aborted), .tdoData(tdoData)
    );

    always #5 jtagClk = ~jtagClk;

    int n_chk = 0, n_pass = 0;
    // IEEE 1149.1 next state for TMS=0 / TMS=1, indexed by the tapState encoding.
    int nx0[16] = '{1, 1, 10, 4, 5, 5, 7, 7, 5, 1, 11, 11, 13, 13, 11, 1};
    int nx1[16] = '{0, 2, 3, 0, 6, 6, 9, 8, 9, 2, 12, 12, 15, 14, 15, 2};

    int          m_state;
    bit          m_busy, m_done, m_aborted;
    logic [31:0] m_tdo;
    bit          tq[$];
    bit          dq[$];
    int          cq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit e_tms();
        return jtagRst || abort || (m_busy && tq.size() > 0 && tq[0]);
    endfunction

    function automatic bit e_tdi();
        return !jtagRst && m_busy && dq.size() > 0 && (m_state == 5 || m_state == 11) && dq[0];
    endfunction

    task automatic model_reset();
        m_state = 0; m_busy = 0; m_done = 0; m_aborted = 0; m_tdo = '0;
        tq.delete(); dq.delete(); cq.delete();
    endtask

    task automatic push(input bit t, input bit d, input int c);
        tq.push_back(t); dq.push_back(d); cq.push_back(c);
    endtask

    // Per-cycle TMS/TDI/capture-index plan of a whole scan, from acceptance to UpdateDr.
    task automatic plan();
        int n, m;
        n = (instrWidth >= 3 && instrWidth <= 5) ? int'(instrWidth) : 5;
        m = (vectorWidth == 8 || vectorWidth == 16 || vectorWidth == 24 || vectorWidth == 32) ? int'(vectorWidth) : 32;
        push(1, 0, -1); push(1, 0, -1); push(0, 0, -1); push(0, 0, -1);
        for (int k = 0; k < n; k++) push(k == n - 1, instruction[k], -1);
        push(1, 0, -1); push(1, 0, -1); push(0, 0, -1); push(0, 0, -1);
        for (int k = 0; k < m; k++) push(k == m - 1, testVector[k], k);
        push(1, 0, -1); push(0, 0, -1);
    endtask

    task automatic model_step();
        bit t, acc, ab;
        int ns;
        t   = e_tms();
        ns  = t ? nx1[m_state] : nx0[m_state];
        acc = start && !abort && !m_busy && m_state == 1;
        ab  = abort && m_state != 0 && ns == 0;
        m_done = 0;
        m_aborted = ab;
        if (m_busy) begin
            if (m_state == 11 && cq.size() > 0 && cq[0] >= 0) m_tdo[cq[0]] = jtagTdo;
            if (tq.size() > 0) begin tq.delete(0); dq.delete(0); cq.delete(0); end
            if (ab) begin
                m_busy = 0; tq.delete(); dq.delete(); cq.delete();
            end else if (tq.size() == 0 && ns == 1) begin
                m_busy = 0; m_done = 1;
            end
        end
        if (acc) begin m_busy = 1; m_tdo = '0; plan(); end
        m_state = ns;
    endtask

    task automatic compare_all();
        chk("tapState", tapState, m_state);
        chk("jtagTms", jtagTms, e_tms());
        chk("jtagTdi", jtagTdi, e_tdi());
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("aborted", aborted, m_aborted);
        chk("tdoData", tdoData, m_tdo);
    endtask

    task automatic tick();
        #1 compare_all();
        @(posedge jtagClk);
        if (!jtagRst) model_step();
        @(negedge jtagClk);
    endtask

    task automatic run_scan(input int bound, output int dc, output logic [31:0] irs, output logic [31:0] drs);
        int ki, kd;
        dc = -1; irs = '0; drs = '0; ki = 0; kd = 0;
        for (int c = 0; c < bound; c++) begin
            if (tapState == 4'd5 && ki < 32) begin irs[ki] = jtagTdi; ki++; end
            if (tapState == 4'd11 && kd < 32) begin drs[kd] = jtagTdi; kd++; end
            if (done) begin dc = c; break; end
            tick();
        end
    endtask

    task automatic wait_state(input int s, input int bound);
        for (int c = 0; c < bound && tapState != 4'(s); c++) tick();
        chk("wait_state", tapState, s);
    endtask

    initial begin
        int          dc, r, ab_hold;
        logic [31:0] irs, drs;
        int          seq[6];
        int          exp_seq[6] = '{11, 12, 15, 2, 3, 0};
        bit          dn_seen;
        model_reset();
        @(negedge jtagClk);
        #1 compare_all();
        @(negedge jtagClk);
        jtagRst = 0;
        tick();
        chk("release_idle", tapState, 1);
        tick();
        chk("idle_stable", tapState, 1);
        chk("idle_not_busy", busy, 0);

        instruction = 5'b00110; instrWidth = 3'd5; testVector = 32'hA5; vectorWidth = 6'd8;
        jtagTdo = 1; start = 1;
        tick();
        start = 0;
        run_scan(60, dc, irs, drs);
        chk("scan_len_23", dc, 23);
        chk("ir_tdi_order", irs, 32'h06);
        chk("dr_tdi_order", drs, 32'hA5);
        chk("tdo_ff", tdoData, 32'hFF);
        tick();

        instruction = 5'($urandom); testVector = $urandom; instrWidth = 3'd7; vectorWidth = 6'd20; start = 1;
        tick();
        run_scan(100, dc, irs, drs);
        chk("scan_len_47", dc, 47);
        tick();
        chk("b2b_busy", busy, 1);
        chk("b2b_idle", tapState, 1);
        start = 0;
        tick();
        chk("b2b_drscan", tapState, 2);
        run_scan(100, dc, irs, drs);
        chk("b2b_len", dc, 46);
        tick();

        instruction = 5'($urandom); testVector = $urandom; instrWidth = 3'd3; vectorWidth = 6'd8;
        jtagTdo = 1; start = 1;
        tick();
        start = 0;
        wait_state(11, 40);
        tick(); tick(); tick();
        abort = 1;
        dn_seen = 0;
        for (int i = 0; i < 6; i++) begin
            seq[i] = int'(tapState);
            dn_seen |= done;
            if (i < 5) tick();
        end
        for (int i = 0; i < 6; i++) chk("abort_path", seq[i], exp_seq[i]);
        chk("abort_pulse", aborted, 1);
        chk("abort_no_done", dn_seen, 0);
        chk("abort_partial_tdo", tdoData[2:0], 3'b111);
        tick();
        chk("abort_hold_reset", tapState, 0);
        chk("abort_single_pulse", aborted, 0);
        abort = 0;
        tick();
        chk("abort_release_idle", tapState, 1);

        instruction = 5'($urandom); testVector = $urandom; instrWidth = 3'd4; vectorWidth = 6'd16; start = 1;
        tick();
        start = 0;
        wait_state(5, 20);
        jtagRst = 1;
        #1 model_reset();
        chk("rst_state", tapState, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tms", jtagTms, 1);
        compare_all();
        @(posedge jtagClk);
        @(negedge jtagClk);
        jtagRst = 0;
        tick();
        chk("rst_to_idle", tapState, 1);

        ab_hold = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            jtagTdo = 1'($urandom); instruction = 5'($urandom); instrWidth = 3'($urandom);
            testVector = $urandom;
            r = int'($urandom % 5);
            vectorWidth = r < 4 ? 6'(8 * (r + 1)) : 6'($urandom);
            start = ($urandom % 3) == 0;
            if (ab_hold > 0) begin
                abort = 1;
                if (m_state == 0) ab_hold--;
            end else begin
                abort = ($urandom % 300) == 0;
                if (abort) ab_hold = int'($urandom_range(1, 3));
            end
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
